// File: rtl/brick_pkg.sv
// Shared brick-row geometry, colour and FSM state type for the brick field.
package brick_pkg;

    localparam int NUM_BLOCKS  = 10;
    localparam int BRICK_X0    = 2;
    localparam int BRICK_PITCH = 64;
    localparam int BRICK_W     = 60;
    localparam int BRICK_Y0    = 40;
    localparam int BRICK_H     = 20;

    localparam logic [23:0] BRICK_COLOR = 24'hFF4000;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } brick_state_e;

    function automatic logic [9:0] brick_x(input logic [3:0] idx);
        return 10'(BRICK_X0 + BRICK_PITCH * int'(idx));
    endfunction

    // Half-open span test widened to 11 bits so start+len never wraps.
    function automatic logic in_span(input logic [9:0] p,
                                     input logic [9:0] start,
                                     input logic [9:0] len);
        return ({1'b0, p} >= {1'b0, start}) &&
               ({1'b0, p} <  ({1'b0, start} + {1'b0, len}));
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle overlap test with 11-bit sums.
module rect_overlap (
    input  logic [9:0] a_x_i,
    input  logic [9:0] a_y_i,
    input  logic [9:0] a_w_i,
    input  logic [9:0] a_h_i,
    input  logic [9:0] b_x_i,
    input  logic [9:0] b_y_i,
    input  logic [9:0] b_w_i,
    input  logic [9:0] b_h_i,
    output logic       overlap_o
);

    logic x_ov;
    logic y_ov;

    assign x_ov = ({1'b0, a_x_i} < ({1'b0, b_x_i} + {1'b0, b_w_i})) &&
                  ({1'b0, b_x_i} < ({1'b0, a_x_i} + {1'b0, a_w_i}));
    assign y_ov = ({1'b0, a_y_i} < ({1'b0, b_y_i} + {1'b0, b_h_i})) &&
                  ({1'b0, b_y_i} < ({1'b0, a_y_i} + {1'b0, a_h_i}));

    assign overlap_o = x_ov && y_ov;

endmodule

// File: rtl/brick_field.sv
// Brick row: scans one brick per cycle for ball hits, holds collide pulses, draws bricks.
// Optional score counter is built only when BRICK_SCORE_EN is defined.
module brick_field
    import brick_pkg::*;
#(
    parameter logic [19:0] HOLD_CYCLES = 20'd416667,
    parameter int          NUM_BLOCKS  = brick_pkg::NUM_BLOCKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  active_pixels,
    input  logic [9:0]            ball_x,
    input  logic [9:0]            ball_y,
    input  logic [9:0]            ball_width,
    input  logic [9:0]            ball_height,
    input  logic [9:0]            paddle_x,
    input  logic [9:0]            paddle_y,
    input  logic [9:0]            paddle_width,
    input  logic [9:0]            paddle_height,
    output logic                  collide_paddle,
    output logic [NUM_BLOCKS-1:0] collide_block,
    output logic [NUM_BLOCKS-1:0] bricks_alive,
    output logic                  all_cleared,
    output logic [7:0]            score,
    output logic [23:0]           vga_color,
    output brick_state_e          state_dbg,
    output logic [3:0]            idx_dbg
);

    brick_state_e          state_q, state_d;
    logic [3:0]            idx_q, idx_d, idx_next;
    logic [19:0]           hold_q, hold_d;
    logic [NUM_BLOCKS-1:0] alive_q, alive_d;
    logic [NUM_BLOCKS-1:0] collide_q, collide_d;
    logic [9:0]            scan_x;
    logic                  brick_ov;

    logic        pad_ov;
    logic        pad_ov_q, pad_ov_prev_q;
    logic        pad_hit_q, pad_hit_d;
    logic [19:0] pad_hold_q, pad_hold_d;

    logic        pix_hit;

    assign scan_x   = brick_x(idx_q);
    assign idx_next = (idx_q == 4'(NUM_BLOCKS - 1)) ? 4'd0 : idx_q + 4'd1;

    rect_overlap u_brick_ov (
        .a_x_i     (ball_x),
        .a_y_i     (ball_y),
        .a_w_i     (ball_width),
        .a_h_i     (ball_height),
        .b_x_i     (scan_x),
        .b_y_i     (10'(BRICK_Y0)),
        .b_w_i     (10'(BRICK_W)),
        .b_h_i     (10'(BRICK_H)),
        .overlap_o (brick_ov)
    );

    rect_overlap u_paddle_ov (
        .a_x_i     (ball_x),
        .a_y_i     (ball_y),
        .a_w_i     (ball_width),
        .a_h_i     (ball_height),
        .b_x_i     (paddle_x),
        .b_y_i     (paddle_y),
        .b_w_i     (paddle_width),
        .b_h_i     (paddle_height),
        .overlap_o (pad_ov)
    );

    // Brick FSM: one hit is accepted, then the row is frozen for the hold window.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        alive_d   = alive_q;
        collide_d = collide_q;
        case (state_q)
            SCAN: begin
                if (alive_q[idx_q] && brick_ov) begin
                    alive_d[idx_q]   = 1'b0;
                    collide_d        = '0;
                    collide_d[idx_q] = 1'b1;
                    hold_d           = HOLD_CYCLES - 20'd1;
                    state_d          = HOLD;
                end else begin
                    idx_d = idx_next;
                end
            end
            HOLD: begin
                if (hold_q == 20'd0) begin
                    collide_d = '0;
                    idx_d     = idx_next;
                    state_d   = (alive_q == '0) ? DONE : SCAN;
                end else begin
                    hold_d = hold_q - 20'd1;
                end
            end
            DONE: begin
                collide_d = '0;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN;
            idx_q     <= 4'd0;
            hold_q    <= 20'd0;
            alive_q   <= '1;
            collide_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            alive_q   <= alive_d;
            collide_q <= collide_d;
        end
    end

    // Paddle hit: rising edge of the registered overlap; ignored while a hold runs.
    always_comb begin
        pad_hit_d  = pad_hit_q;
        pad_hold_d = pad_hold_q;
        if (pad_hit_q) begin
            if (pad_hold_q == 20'd0) begin
                pad_hit_d = 1'b0;
            end else begin
                pad_hold_d = pad_hold_q - 20'd1;
            end
        end else if (pad_ov_q && !pad_ov_prev_q) begin
            pad_hit_d  = 1'b1;
            pad_hold_d = HOLD_CYCLES - 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_ov_q      <= 1'b0;
            pad_ov_prev_q <= 1'b0;
            pad_hit_q     <= 1'b0;
            pad_hold_q    <= 20'd0;
        end else begin
            pad_ov_q      <= pad_ov;
            pad_ov_prev_q <= pad_ov_q;
            pad_hit_q     <= pad_hit_d;
            pad_hold_q    <= pad_hold_d;
        end
    end

`ifdef BRICK_SCORE_EN
    logic [7:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (((alive_q & ~alive_d) != '0) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= 8'h00;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 8'h00;
`endif

    always_comb begin
        pix_hit = 1'b0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (alive_q[i] &&
                in_span(x, brick_x(4'(i)), 10'(BRICK_W)) &&
                in_span(y, 10'(BRICK_Y0), 10'(BRICK_H))) begin
                pix_hit = 1'b1;
            end
        end
    end

    assign vga_color      = (active_pixels && pix_hit) ? BRICK_COLOR : 24'h000000;
    assign collide_paddle = pad_hit_q;
    assign collide_block  = collide_q;
    assign bricks_alive   = alive_q;
    assign all_cleared    = (state_q == DONE);
    assign state_dbg      = state_q;
    assign idx_dbg        = idx_q;

endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: per-cycle reference model plus directed literal scenarios.
module tb_brick_field;
    import brick_pkg::*;

    localparam int NB = 10;
    localparam int H  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   x, y;
    logic         active_pixels;
    logic [9:0]   ball_x, ball_y, ball_width, ball_height;
    logic [9:0]   paddle_x, paddle_y, paddle_width, paddle_height;
    logic         collide_paddle;
    logic [NB-1:0] collide_block;
    logic [NB-1:0] bricks_alive;
    logic         all_cleared;
    logic [7:0]   score;
    logic [23:0]  vga_color;
    brick_state_e state_dbg;
    logic [3:0]   idx_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    brick_field #(.HOLD_CYCLES(20'd16), .NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
        .ball_x(ball_x), .ball_y(ball_y), .ball_width(ball_width), .ball_height(ball_height),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_width(paddle_width),
        .paddle_height(paddle_height), .collide_paddle(collide_paddle),
        .collide_block(collide_block), .bricks_alive(bricks_alive),
        .all_cleared(all_cleared), .score(score), .vga_color(vga_color),
        .state_dbg(state_dbg), .idx_dbg(idx_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference helpers
    function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic logic [23:0] exp_pixel(int px, int py, bit act, logic [NB-1:0] alive);
        if (!act) return 24'h000000;
        for (int i = 0; i < NB; i++) begin
            if (alive[i] && px >= 2 + 64 * i && px < 62 + 64 * i && py >= 40 && py < 60)
                return 24'hFF4000;
        end
        return 24'h000000;
    endfunction

    function automatic int exp_score(int n);
`ifdef BRICK_SCORE_EN
        return (n > 255) ? 255 : n;
`else
        return (n > 255) ? 0 : 0 * n;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle model: bricks die when hit, hits last H cycles, paddle pulses on overlap onset
    logic [NB-1:0] m_alive;
    logic [NB-1:0] m_blk_bit;
    int  m_blk_left, m_pad_left, m_score, pending;
    bit  ov1, ov2, armed;
    bit  s_rst;
    int  s_bx, s_by, s_bw, s_bh, s_px, s_py, s_pw, s_ph;

    initial begin : compare
        logic [NB-1:0] exp_blk;
        bit blk_high, chk_blk, any, ok, rise;
        int j;
        armed = 0;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_bx = int'(ball_x);   s_by = int'(ball_y);
            s_bw = int'(ball_width); s_bh = int'(ball_height);
            s_px = int'(paddle_x); s_py = int'(paddle_y);
            s_pw = int'(paddle_width); s_ph = int'(paddle_height);
            @(negedge clk);
            exp_blk  = '0;
            blk_high = 0;
            chk_blk  = 1;
            if (s_rst) begin
                m_alive = '1; m_blk_bit = '0; m_blk_left = 0; m_pad_left = 0;
                m_score = 0; pending = 0; ov1 = 0; ov2 = 0; armed = 1;
            end else if (armed) begin
                rise = ov1 && !ov2;
                if (m_pad_left > 0) m_pad_left--;
                else if (rise) m_pad_left = H;
                ov2 = ov1;
                ov1 = ovl(s_bx, s_by, s_bw, s_bh, s_px, s_py, s_pw, s_ph);

                if (m_blk_left > 0) begin
                    exp_blk = m_blk_bit; blk_high = 1; m_blk_left--; pending = 0;
                end else if (collide_block != '0) begin
                    j = 0;
                    for (int i = NB - 1; i >= 0; i--) if (collide_block[i]) j = i;
                    ok = $onehot(collide_block) && m_alive[j] &&
                         ovl(s_bx, s_by, s_bw, s_bh, 2 + 64 * j, 40, 60, 20);
                    tests_run++;
                    if (!ok) begin
                        tests_failed++;
                        $display("FAIL m_hit_valid: collide_block=0x%0h, required a single alive brick under the ball (alive=0x%0h)",
                                 collide_block, m_alive);
                    end
                    m_alive[j] = 1'b0; m_score++;
                    m_blk_bit = '0; m_blk_bit[j] = 1'b1;
                    m_blk_left = H - 1; blk_high = 1; chk_blk = 0; pending = 0;
                end else begin
                    any = 0;
                    for (int i = 0; i < NB; i++)
                        if (m_alive[i] && ovl(s_bx, s_by, s_bw, s_bh, 2 + 64 * i, 40, 60, 20)) any = 1;
                    if (any) begin
                        pending++;
                        tests_run++;
                        if (pending > NB) begin
                            tests_failed++;
                            $display("FAIL m_latency: %0d cycles without collide_block, required at most %0d", pending, NB);
                        end
                    end else begin
                        pending = 0;
                    end
                end
            end
            if (armed) begin
                if (chk_blk) chk("m_collide_block", collide_block, exp_blk);
                chk("m_bricks_alive", bricks_alive, m_alive);
                chk("m_collide_paddle", collide_paddle, (m_pad_left > 0));
                chk("m_all_cleared", all_cleared, (m_alive == '0) && !blk_high);
                chk("m_score", score, exp_score(m_score));
                chk("m_vga_color", vga_color, exp_pixel(int'(x), int'(y), active_pixels, m_alive));
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ball(input int bx, input int by);
        ball_x = 10'(bx); ball_y = 10'(by);
    endtask

    task automatic set_pixel(input int px, input int py, input bit act);
        x = 10'(px); y = 10'(py); active_pixels = act;
    endtask

    task automatic wait_blk_high(input string name);
        bit seen = 0;
        for (int k = 0; k < NB + 4 && !seen; k++) begin
            @(negedge clk);
            if (collide_block != '0) seen = 1;
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL %s: collide_block stayed 0x0, required a hit within %0d cycles", name, NB);
        end
    endtask

    task automatic wait_blk_low(input string name, output int high_cycles);
        bit gone = 0;
        high_cycles = 1;
        for (int k = 0; k < H + 4 && !gone; k++) begin
            @(negedge clk);
            if (collide_block == '0) gone = 1;
            else high_cycles++;
        end
        if (!gone) begin
            tests_run++; tests_failed++;
            $display("FAIL %s: collide_block still 0x%0h, required 0x0 after %0d cycles", name, collide_block, H);
        end
    endtask

    task automatic hit_brick(input int i);
        int n;
        tick();
        set_ball(22 + 64 * i, 45);
        wait_blk_high($sformatf("hit_%0d_wait", i));
        chk($sformatf("hit_%0d", i), collide_block, 32'(1 << i));
        wait_blk_low($sformatf("hit_%0d_end", i), n);
        tick();
        set_ball(100, 200);
    endtask

    // Directed scenarios
    initial begin : stimulus
        int n;
        set_ball(100, 200);
        ball_width = 10'd20; ball_height = 10'd20;
        paddle_x = 10'd300; paddle_y = 10'd440; paddle_width = 10'd80; paddle_height = 10'd10;
        set_pixel(30, 50, 1'b1);
        tick(3);
        rst = 1'b0;

        @(negedge clk);
        chk("rst_alive", bricks_alive, 32'h3FF);
        chk("rst_collide_block", collide_block, 32'h0);
        chk("rst_collide_paddle", collide_paddle, 32'h0);
        chk("rst_all_cleared", all_cleared, 32'h0);
        chk("rst_score", score, 32'h0);
        chk("rst_vga_30_50", vga_color, 32'hFF4000);

        tick(); set_pixel(61, 50, 1'b1); @(negedge clk); chk("vga_61_50", vga_color, 32'hFF4000);
        tick(); set_pixel(62, 50, 1'b1); @(negedge clk); chk("vga_62_50_gap", vga_color, 32'h0);
        tick(); set_pixel(30, 60, 1'b1); @(negedge clk); chk("vga_30_60_below", vga_color, 32'h0);
        tick(); set_pixel(30, 39, 1'b1); @(negedge clk); chk("vga_30_39_above", vga_color, 32'h0);
        tick(); set_pixel(30, 50, 1'b0); @(negedge clk); chk("vga_blank", vga_color, 32'h0);
        tick(); set_pixel(30, 50, 1'b1);

        set_ball(70, 45);
        wait_blk_high("b1_wait");
        chk("b1_collide", collide_block, 32'h002);
        wait_blk_low("b1_end", n);
        chk("b1_hold_len", n, H);
        tick(); set_ball(100, 200);
        @(negedge clk);
        chk("b1_alive", bricks_alive, 32'h3FD);
        chk("b1_score", score, exp_score(1));

        tick(); set_ball(310, 435);
        tick(); set_ball(330, 45);
        wait_blk_high("b5_wait");
        chk("b5_collide", collide_block, 32'h020);
        chk("b5_paddle_same", collide_paddle, 32'h1);
        wait_blk_low("b5_end", n);
        tick(); set_ball(100, 200);

        for (int i = 0; i < NB; i++) begin
            if (i != 1 && i != 5) hit_brick(i);
        end
        @(negedge clk);
        chk("clr_all_cleared", all_cleared, 32'h1);
        chk("clr_state_done", 32'(state_dbg), 32'(DONE));
        chk("clr_alive", bricks_alive, 32'h0);
        chk("clr_score", score, exp_score(10));
        for (int i = 0; i < NB; i++) begin
            tick(); set_pixel(32 + 64 * i, 50, 1'b1);
            @(negedge clk);
            chk($sformatf("clr_vga_%0d", i), vga_color, 32'h0);
        end
        tick(); set_ball(310, 435);
        n = 0;
        for (int k = 0; k < 5 && n == 0; k++) begin
            @(negedge clk);
            if (collide_paddle) n = 1;
        end
        chk("done_paddle", n, 1);
        chk("done_collide_block", collide_block, 32'h0);
        tick(); set_ball(100, 200);
        tick(H + 4);

        rst = 1'b1; tick(2); rst = 1'b0;
        @(negedge clk);
        chk("rst2_alive", bricks_alive, 32'h3FF);
        chk("rst2_state", 32'(state_dbg), 32'(SCAN));
        tick(); set_ball(214, 45);
        wait_blk_high("b3_wait");
        chk("b3_collide", collide_block, 32'h008);
        repeat (4) @(negedge clk);
        chk("b3_mid_hold", collide_block, 32'h008);
        tick(); rst = 1'b1; set_ball(100, 200);
        tick();
        @(negedge clk);
        chk("rst_hold_collide", collide_block, 32'h0);
        chk("rst_hold_alive", bricks_alive, 32'h3FF);
        chk("rst_hold_score", score, 32'h0);
        tick(); rst = 1'b0;

        set_ball(598, 45);
        wait_blk_high("b9_wait");
        chk("b9_collide", collide_block, 32'h200);
        wait_blk_low("b9_end", n);
        chk("b9_idx_wrap", idx_dbg, 32'h0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 1) set_ball(630, 45);
            @(negedge clk);
            chk($sformatf("idx_cycle_%0d", k), idx_dbg, 32'(k % NB));
            chk($sformatf("dead9_no_hit_%0d", k), collide_block, 32'h0);
        end
        chk("dead9_alive", bricks_alive, 32'h1FF);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
